stack_arbiter: RTL and testbench

STACK_ARBITER -- requirements
Module: stack_arbiter

---
 rtl/stack_arbiter_if.sv | 26 ++
 rtl/stack_arbiter.sv | 123 ++++++++++++
 tb/tb_stack_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_arbiter_if.sv
// Requester and stack-port bundle for stack_arbiter.
// master: requesters plus stack storage side; slave: the arbiter.
// Every signal is a plain wire-level handshake, with no flow control beyond req/done/nak.
interface stack_arbiter_if #(parameter int WIDTH = 2);
  logic             req0, req1;
  logic             op0, op1;
  logic [WIDTH-1:0] din0, din1;
  logic             gnt0, gnt1;
  logic             done0, done1;
  logic             nak0, nak1;
  logic [WIDTH-1:0] dout;
  logic             stk_push, stk_pop;
  logic [WIDTH-1:0] stk_din;
  logic [WIDTH-1:0] stk_dout;
  logic             stk_full, stk_empty;

  modport master (
    output req0, req1, op0, op1, din0, din1, stk_dout, stk_full, stk_empty,
    input  gnt0, gnt1, done0, done1, nak0, nak1, dout, stk_push, stk_pop, stk_din
  );

  modport slave (
    input  req0, req1, op0, op1, din0, din1, stk_dout, stk_full, stk_empty,
    output gnt0, gnt1, done0, done1, nak0, nak1, dout, stk_push, stk_pop, stk_din
  );
endinterface

// File: rtl/stack_arbiter.sv
// Round-robin arbiter giving two requesters push/pop access to one stack.
// Latency req->done: push 3, pop 4, nak 3 cycles; a requester holds req until done/nak.
// Optional STACK_ARB_STATS_EN adds a saturating 8-bit nak counter output (nak_cnt).
module stack_arbiter #(
  parameter int WIDTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  stack_arbiter_if.slave bus
`ifdef STACK_ARB_STATS_EN
  ,
  output logic [7:0]     nak_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  state_t           state, state_nxt;
  logic             idx;       // granted requester
  logic             op_r;      // 1 = push
  logic             ok_r;      // operation accepted by the stack
  logic             last;      // last-served requester
  logic [WIDTH-1:0] din_r;
  logic [WIDTH-1:0] dout_r;
  logic             any_req;
  logic             win;
  logic             issue_ok;
  logic             gnt_on;
  logic             resp_done, resp_nak;
  logic             push, pop;

  // Round-robin pick: a lone request wins, a tie goes to the requester not served last.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    win     = 1'b0;
    if (bus.req0 && bus.req1) win = ~last;
    else if (bus.req1)        win = 1'b1;
  end

  assign issue_ok = op_r ? ~bus.stk_full : ~bus.stk_empty;

  // Next-state and per-state strobes; grant in IDLE is combinational so it shows in the request cycle.
  always_comb begin
    state_nxt = state;
    gnt_on    = 1'b0;
    resp_done = 1'b0;
    resp_nak  = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (any_req && !rst) begin
          gnt_on    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        gnt_on = 1'b1;
        if (issue_ok) begin
          push = op_r;
          pop  = ~op_r;
        end
        state_nxt = (issue_ok && !op_r) ? CAPT : RESP;
      end
      CAPT: begin
        gnt_on    = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        gnt_on    = 1'b1;
        resp_done = ok_r;
        resp_nak  = ~ok_r;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The grant index in IDLE is the live winner; afterwards it is the latched one.
  assign bus.gnt0     = gnt_on & ((state == IDLE) ? ~win : ~idx);
  assign bus.gnt1     = gnt_on & ((state == IDLE) ?  win :  idx);
  assign bus.done0    = resp_done & ~idx;
  assign bus.done1    = resp_done &  idx;
  assign bus.nak0     = resp_nak  & ~idx;
  assign bus.nak1     = resp_nak  &  idx;
  assign bus.stk_push = push;
  assign bus.stk_pop  = pop;
  assign bus.stk_din  = din_r;
  assign bus.dout     = dout_r;

  // State register plus the operation latched at grant; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= 1'b0;
      op_r   <= 1'b0;
      ok_r   <= 1'b0;
      last   <= 1'b1;
      din_r  <= '0;
      dout_r <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        idx   <= win;
        last  <= win;
        op_r  <= win ? bus.op1  : bus.op0;
        din_r <= win ? bus.din1 : bus.din0;
      end
      if (state == ISSUE) ok_r <= issue_ok;
      // Stack read data is registered at the pop edge, so it is valid during CAPT.
      if (state == CAPT) dout_r <= bus.stk_dout;
    end
  end

`ifdef STACK_ARB_STATS_EN
  // Count nak pulses, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) nak_cnt <= 8'd0;
    else if (resp_nak && nak_cnt != 8'hFF) nak_cnt <= nak_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: directed vector table, corner sequences, randomized run vs transaction model.
// Provides a depth-4 behavioural stack with force flags for full/empty.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_stack_arbiter;
  localparam int WIDTH = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stack_arbiter_if #(.WIDTH(WIDTH)) bus();
`ifdef STACK_ARB_STATS_EN
  logic [7:0] nak_cnt;
`endif

  stack_arbiter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef STACK_ARB_STATS_EN
    ,
    .nak_cnt (nak_cnt)
`endif
  );

  // Behavioural stack storage
  logic [WIDTH-1:0] smem [DEPTH];
  int   scount;
  logic force_full, force_empty;
  assign bus.stk_full  = (scount == DEPTH) || force_full;
  assign bus.stk_empty = (scount == 0) || force_empty;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      scount       <= 0;
      bus.stk_dout <= '0;
    end else if (bus.stk_push && scount < DEPTH) begin
      smem[scount] <= bus.stk_din;
      scount       <= scount + 1;
    end else if (bus.stk_pop && scount > 0) begin
      bus.stk_dout <= smem[scount-1];
      scount       <= scount - 1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [7:0] outs();
    return {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.nak0, bus.nak1, bus.stk_push, bus.stk_pop};
  endfunction

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.op0  = 1'b0; bus.op1  = 1'b0;
    bus.din0 = '0;   bus.din1 = '0;
    force_full = 1'b0; force_empty = 1'b0;
  endtask

  // Leaves time at posedge+1 with rst low.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic       r0, r1, op0, op1;
    logic [1:0] d0, d1;
    logic       ff, fe;
    logic       w;      // expected winner
    logic       ok;     // done (1) or nak (0)
    int         lat;    // req-to-response cycles
    logic [1:0] dout;   // dout in response cycle
  } vec_t;

  vec_t vt[10];

  // One transaction from posedge+1 in IDLE; returns at posedge+1 in IDLE with requests dropped.
  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] o;
    logic [1:0] exp_gnt;
    logic [3:0] exp_resp;
    logic [1:0] exp_stb;
    logic       bad_hold;
    bad_hold = 1'b0;
    exp_gnt  = v.w ? 2'b01 : 2'b10;
    exp_resp = {v.ok & ~v.w, v.ok & v.w, ~v.ok & ~v.w, ~v.ok & v.w};
    exp_stb  = !v.ok ? 2'b00 : ((v.w ? v.op1 : v.op0) ? 2'b10 : 2'b01);
    bus.req0 = v.r0; bus.req1 = v.r1;
    bus.op0  = v.op0; bus.op1 = v.op1;
    bus.din0 = v.d0;  bus.din1 = v.d1;
    force_full = v.ff; force_empty = v.fe;
    for (int c = 1; c <= v.lat; c++) begin
      @(negedge clk);
      o = outs();
      if (o[7:6] != exp_gnt) bad_hold = 1'b1;
      if (c == 1) check({tag, " gnt"}, 32'(o[7:6]), 32'(exp_gnt));
      if (c == 2) begin
        check({tag, " strobe"}, 32'(o[1:0]), 32'(exp_stb));
        if (exp_stb == 2'b10) check({tag, " stk_din"}, 32'(bus.stk_din), 32'(v.w ? v.d1 : v.d0));
      end
      if (c != 2 && o[1:0] != 2'b00) bad_hold = 1'b1;
      if (c < v.lat && o[5:2] != 4'b0000) bad_hold = 1'b1;
      if (c == v.lat) begin
        check({tag, " resp"}, 32'(o[5:2]), 32'(exp_resp));
        check({tag, " dout"}, 32'(bus.dout), 32'(v.dout));
      end
    end
    check({tag, " gnt-hold/no-early"}, 32'(bad_hold), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
  endtask

  // Randomized-phase reference: transaction-level view of arbiter plus stack contents.
  int         q[$];
  bit         m_busy, m_w, m_op, m_ok, m_last;
  int         m_t, m_len;
  logic [1:0] m_din, m_dout, m_pend;
  bit         act[2], fin[2];
  logic       opv[2];
  logic [1:0] dv[2];

  initial begin
    vec_t       v;
    logic [7:0] o, e;
    int         dq[$];
    bit         overlap;

    // r0 r1 op0 op1 d0 d1 ff fe | w ok lat dout
    vt[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 2'd0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 2'd2};
    vt[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 2'd2};
    vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 3, 2'd2};
    vt[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 3, 2'd2};
    vt[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 3, 2'd2};
    vt[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 2'd1};
    vt[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 2'd3};
    vt[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 3, 2'd3};
    vt[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 2'd3};

    // Reset state, with a request pending to show grant is held off
    idle_inputs();
    rst = 1'b1;
    bus.req0 = 1'b1;
    #12;
    check("reset outs", 32'(outs()), 32'd0);
    check("reset dout", 32'(bus.dout), 32'd0);
    do_reset();
`ifdef STACK_ARB_STATS_EN
    check("nak_cnt after reset", 32'(nak_cnt), 32'd0);
`endif

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_vec(vt[i], $sformatf("vec%0d", i));
`ifdef STACK_ARB_STATS_EN
      if (i == 2) check("nak_cnt first nak", 32'(nak_cnt), 32'd1);
      if (i == 9) check("nak_cnt three naks", 32'(nak_cnt), 32'd3);
`endif
    end

    // Both requesters held for pushes: grants alternate starting with 0
    do_reset();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.op0  = 1'b1; bus.op1  = 1'b1;
    overlap = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      o = outs();
      if (o[7] && o[6]) overlap = 1'b1;
      if ((o[5] || o[4]) && (o[5] == o[4])) overlap = 1'b1;
      if (o[5]) dq.push_back(0);
      if (o[4]) dq.push_back(1);
    end
    @(posedge clk); #1 idle_inputs();
    check("alt no overlap", 32'(overlap), 32'd0);
    check("alt count", 32'(dq.size()), 32'd4);
    for (int k = 0; k < 4 && k < dq.size(); k++)
      check($sformatf("alt order %0d", k), 32'(dq[k]), 32'(k % 2));

    // Reset during CAPT
    do_reset();
    v = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 2'd0};
    run_vec(v, "pre push a");
    v = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 2'd0};
    run_vec(v, "pre push b");
    v = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 2'd1};
    run_vec(v, "pre pop");
    bus.req0 = 1'b1; bus.op0 = 1'b0;
    repeat (3) @(negedge clk);
    check("capt gnt0 before rst", 32'(outs()), 32'h80);
    rst = 1'b1;
    #1;
    check("async rst outs", 32'(outs()), 32'd0);
    check("async rst dout", 32'(bus.dout), 32'd0);
    @(posedge clk); #1;
    check("rst held no done", 32'(outs()), 32'd0);
    rst = 1'b0;
    v = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 3, 2'd0};
    run_vec(v, "post rst");

`ifdef STACK_ARB_STATS_EN
    // Saturation: 300 naks on a full stack
    do_reset();
    force_full = 1'b1;
    bus.req0 = 1'b1; bus.op0 = 1'b1;
    repeat (905) @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    check("nak_cnt saturates", 32'(nak_cnt), 32'd255);
`endif

    // Randomized run against the transaction-level model
    do_reset();
    q.delete();
    m_busy = 0; m_last = 1; m_t = 0; m_len = 0; m_dout = '0; m_pend = '0;
    m_w = 0; m_op = 0; m_ok = 0; m_din = '0;
    act[0] = 0; act[1] = 0; fin[0] = 0; fin[1] = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (act[n] && fin[n]) begin
          act[n] = ($urandom_range(0, 1) == 1);
          fin[n] = 0;
        end else if (!act[n]) begin
          act[n] = ($urandom_range(0, 2) == 0);
        end
        opv[n] = 1'($urandom_range(0, 1));
        dv[n]  = 2'($urandom_range(0, 3));
      end
      bus.req0 = act[0]; bus.req1 = act[1];
      bus.op0  = opv[0]; bus.op1  = opv[1];
      bus.din0 = dv[0];  bus.din1 = dv[1];
      @(negedge clk);
      if (m_busy) m_t++;
      else if (act[0] || act[1]) begin
        m_w    = (act[0] && act[1]) ? !m_last : act[1];
        m_last = m_w;
        m_op   = opv[m_w];
        m_din  = dv[m_w];
        m_ok   = m_op ? (q.size() < DEPTH) : (q.size() > 0);
        m_len  = (m_ok && !m_op) ? 4 : 3;
        m_busy = 1;
        m_t    = 1;
      end
      e = 8'd0;
      if (m_busy) begin
        e[7] = !m_w;
        e[6] = m_w;
        if (m_t == 2 && m_ok) begin
          e[1] = m_op;
          e[0] = !m_op;
          if (m_op) q.push_back(int'(m_din));
          else m_pend = 2'(q.pop_back());
        end
        if (m_t == m_len) begin
          e[5] = m_ok && !m_w;
          e[4] = m_ok && m_w;
          e[3] = !m_ok && !m_w;
          e[2] = !m_ok && m_w;
          if (m_ok && !m_op) m_dout = m_pend;
        end
      end
      o = outs();
      check($sformatf("rand c%0d outs", cyc), 32'(o), 32'(e));
      check($sformatf("rand c%0d dout", cyc), 32'(bus.dout), 32'(m_dout));
      if (e[1]) check($sformatf("rand c%0d stk_din", cyc), 32'(bus.stk_din), 32'(m_din));
      fin[0] = fin[0] | bus.done0 | bus.nak0;
      fin[1] = fin[1] | bus.done1 | bus.nak1;
      if (m_busy && m_t == m_len) m_busy = 0;
      @(posedge clk); #1;
    end
    idle_inputs();
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
